// File: rtl/stream_resp_cntl.sv
// Stream response controller: turns edge-triggered filter/input requests from a
// PE into buffer read bursts and a ready/valid word stream. Filter transfers have
// priority over input transfers, and each transfer reports completion on its own
// finish output.
//
// Read path: a registered read strobe, memory data one cycle later, then a
// presented output word (stream_* registers) backed by a 2-entry FIFO. A new read
// is issued only while FIFO occupancy plus the read still in flight is below 2.
// That bound keeps at most two reads outstanding, never overflows the FIFO if the
// consumer stalls, and still streams one word per cycle when stream_ready stays high.
module stream_resp_cntl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Req_Stream_filter_valid,
    input  logic              Req_Stream_input_valid,
    input  logic [ADDR_W-1:0] filter_base,
    input  logic [ADDR_W-1:0] input_base,
    input  logic [ADDR_W-1:0] filter_len,
    input  logic [ADDR_W-1:0] input_len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              stream_valid,
    input  logic              stream_ready,
    output logic [DATA_W-1:0] stream_data,
    output logic              stream_is_filter,
    output logic [ADDR_W-1:0] stream_idx,
    output logic              Stream_filter_finish,
    output logic              Stream_input_finish_PE
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILTER = 2'd1,
        S_INPUT  = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Registered state
    state_e            state_q, state_d;
    logic              req_f_q, req_i_q;
    logic              pend_f_q, pend_f_d;
    logic              pend_i_q, pend_i_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] left_q, left_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_en_q, rd_en_d;
    logic              rd_vld_q;
    logic [DATA_W-1:0] fifo_mem_q [2];
    logic              fifo_wp_q, fifo_wp_d;
    logic              fifo_rp_q, fifo_rp_d;
    logic [1:0]        fifo_cnt_q, fifo_cnt_d;
    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_is_f_q, out_is_f_d;
    logic [ADDR_W-1:0] out_idx_q, out_idx_d;
    logic              fin_f_q, fin_f_d;
    logic              fin_i_q, fin_i_d;

    // Combinational control terms
    logic              filt_edge, inp_edge;
    logic              active, do_pop, xfer_done;
    logic              may_start, start_f, start_i, start_any;
    logic [ADDR_W-1:0] start_base, start_len;
    logic              out_free, fifo_pop, fifo_push;
    logic [2:0]        outstanding;

    // Request edges, transfer completion and next-transfer selection
    always_comb begin
        filt_edge  = Req_Stream_filter_valid & ~req_f_q;
        inp_edge   = Req_Stream_input_valid & ~req_i_q;
        active     = (state_q != S_IDLE);
        do_pop     = out_vld_q & stream_ready;
        // A zero-length transfer completes in its first cycle.
        xfer_done  = active & ((len_q == ADDR_ZERO) |
                               (do_pop & (out_idx_q == (len_q - ADDR_ONE))));
        may_start  = (state_q == S_IDLE) | xfer_done;
        start_f    = may_start & pend_f_q;
        start_i    = may_start & ~pend_f_q & pend_i_q;
        start_any  = start_f | start_i;
        start_base = start_f ? filter_base : input_base;
        start_len  = start_f ? filter_len : input_len;
    end

    // Output word register and FIFO bookkeeping
    always_comb begin
        out_free   = ~out_vld_q | do_pop;
        fifo_pop   = out_free & (fifo_cnt_q != 2'd0);
        // Arriving data bypasses the FIFO when the output slot is free and the FIFO is empty.
        fifo_push  = rd_vld_q & ~(out_free & (fifo_cnt_q == 2'd0));
        fifo_cnt_d = fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
        fifo_wp_d  = fifo_wp_q ^ fifo_push;
        fifo_rp_d  = fifo_rp_q ^ fifo_pop;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        if (out_free) begin
            if (fifo_cnt_q != 2'd0) begin
                out_vld_d  = 1'b1;
                out_data_d = fifo_mem_q[fifo_rp_q];
            end else if (rd_vld_q) begin
                out_vld_d  = 1'b1;
                out_data_d = mem_rd_data;
            end else begin
                out_vld_d  = 1'b0;
            end
        end else begin
            out_vld_d  = out_vld_q;
        end
        if (start_any | xfer_done) begin
            out_idx_d = ADDR_ZERO;
        end else if (do_pop) begin
            out_idx_d = out_idx_q + ADDR_ONE;
        end else begin
            out_idx_d = out_idx_q;
        end
    end

    // Read issue: the first read launches on state entry, later reads are flow-controlled
    always_comb begin
        outstanding = {1'b0, fifo_cnt_d} + {2'b00, rd_en_q};
        len_d       = len_q;
        left_d      = left_q;
        rd_addr_d   = rd_addr_q;
        rd_en_d     = 1'b0;
        if (start_any) begin
            len_d     = start_len;
            rd_addr_d = start_base;
            rd_en_d   = (start_len != ADDR_ZERO);
            left_d    = (start_len != ADDR_ZERO) ? (start_len - ADDR_ONE) : ADDR_ZERO;
        end else if (active && (left_q != ADDR_ZERO) && (outstanding < 3'd2)) begin
            rd_en_d   = 1'b1;
            rd_addr_d = rd_addr_q + ADDR_ONE;
            left_d    = left_q - ADDR_ONE;
        end else begin
            rd_en_d   = 1'b0;
        end
    end

    // FSM next state, pending requests and completion status
    always_comb begin
        // An edge while the pending bit is set (or being consumed) is dropped.
        pend_f_d = start_f ? 1'b0 : (pend_f_q | filt_edge);
        pend_i_d = start_i ? 1'b0 : (pend_i_q | inp_edge);
        if (start_f) begin
            state_d = S_FILTER;
        end else if (start_i) begin
            state_d = S_INPUT;
        end else if (xfer_done) begin
            state_d = S_IDLE;
        end else begin
            state_d = state_q;
        end
        // Completion of a filter transfer wins over the clear from a back-to-back filter entry.
        if (xfer_done && (state_q == S_FILTER)) begin
            fin_f_d = 1'b1;
        end else if (start_f) begin
            fin_f_d = 1'b0;
        end else begin
            fin_f_d = fin_f_q;
        end
        fin_i_d = xfer_done & (state_q == S_INPUT);
        if (start_f) begin
            out_is_f_d = 1'b1;
        end else if (start_i) begin
            out_is_f_d = 1'b0;
        end else begin
            out_is_f_d = out_is_f_q;
        end
    end

    // State register update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            req_f_q       <= 1'b0;
            req_i_q       <= 1'b0;
            pend_f_q      <= 1'b0;
            pend_i_q      <= 1'b0;
            len_q         <= ADDR_ZERO;
            left_q        <= ADDR_ZERO;
            rd_addr_q     <= ADDR_ZERO;
            rd_en_q       <= 1'b0;
            rd_vld_q      <= 1'b0;
            fifo_mem_q[0] <= {DATA_W{1'b0}};
            fifo_mem_q[1] <= {DATA_W{1'b0}};
            fifo_wp_q     <= 1'b0;
            fifo_rp_q     <= 1'b0;
            fifo_cnt_q    <= 2'd0;
            out_vld_q     <= 1'b0;
            out_data_q    <= {DATA_W{1'b0}};
            out_is_f_q    <= 1'b0;
            out_idx_q     <= ADDR_ZERO;
            fin_f_q       <= 1'b0;
            fin_i_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_f_q    <= Req_Stream_filter_valid;
            req_i_q    <= Req_Stream_input_valid;
            pend_f_q   <= pend_f_d;
            pend_i_q   <= pend_i_d;
            len_q      <= len_d;
            left_q     <= left_d;
            rd_addr_q  <= rd_addr_d;
            rd_en_q    <= rd_en_d;
            rd_vld_q   <= rd_en_q;
            if (fifo_push) begin
                fifo_mem_q[fifo_wp_q] <= mem_rd_data;
            end
            fifo_wp_q  <= fifo_wp_d;
            fifo_rp_q  <= fifo_rp_d;
            fifo_cnt_q <= fifo_cnt_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_is_f_q <= out_is_f_d;
            out_idx_q  <= out_idx_d;
            fin_f_q    <= fin_f_d;
            fin_i_q    <= fin_i_d;
        end
    end

    assign mem_rd_en              = rd_en_q;
    assign mem_rd_addr            = rd_addr_q;
    assign stream_valid           = out_vld_q;
    assign stream_data            = out_data_q;
    assign stream_is_filter       = out_is_f_q;
    assign stream_idx             = out_idx_q;
    assign Stream_filter_finish   = fin_f_q;
    assign Stream_input_finish_PE = fin_i_q;

endmodule
